tt_um_accum_step_decoder: RTL and testbench



---
 rtl/tt_um_accum_step_decoder.sv | 147 ++++++++++++++
 tb/tb_tt_um_accum_step_decoder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_accum_step_decoder.sv
// tt_um_accum_step_decoder
// Recovers the constant step of the companion 16-bit step accumulator tile by
// watching its high byte. Over 256 clocks the high byte advances by exactly the
// step (mod 256), so each 256-cycle window yields one step estimate. 2^AVG_LOG2
// consecutive windows are summed and averaged into one result. The result is
// offered on uo_out with a valid/ack handshake on the bidirectional pins.
// AVG_LOG2 must be in 0..3.

module tt_um_accum_step_decoder #(
    parameter int AVG_LOG2 = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_MEASURE = 2'b01;
    localparam logic [1:0] S_DONE    = 2'b10;

    localparam int SUM_W = 8 + AVG_LOG2;
    localparam logic [AVG_LOG2:0] WIDX_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

    logic [1:0]        state;
    logic [7:0]        ref_val;
    logic [7:0]        cnt;
    logic [SUM_W-1:0]  sum;
    logic [AVG_LOG2:0] widx;
    logic              start_prev;
    logic [7:0]        result;
    logic              valid;
    logic              overrun;

    logic              start;
    logic              ack;
    logic              cont;
    logic              start_edge;
    logic              win_end;
    logic              final_win;
    logic [7:0]        delta;
    logic [SUM_W-1:0]  sum_next;
    logic [7:0]        avg;
    logic              unused_ok;

    assign start = uio_in[0];
    assign ack   = uio_in[1];
    assign cont  = uio_in[2];

    // ena and the upper bidirectional inputs have no function in this block
    assign unused_ok = &{1'b0, ena, uio_in[7:3]};

    assign start_edge = start & ~start_prev;
    assign win_end    = (state == S_MEASURE) && (cnt == 8'hFF);
    assign final_win  = win_end && (widx == WIDX_LAST);

    // The 8-bit modulo subtraction absorbs wrap-around of the observed high byte
    assign delta    = ui_in - ref_val;
    assign sum_next = sum + SUM_W'(delta);
    assign avg      = 8'(sum_next >> AVG_LOG2);

    // Remember the previous start level so only a rising edge launches a measurement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_prev <= 1'b0;
        end else begin
            start_prev <= start;
        end
    end

    // Measurement sequencer: window counter, reference sample and window sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ref_val <= 8'd0;
            cnt     <= 8'd0;
            sum     <= '0;
            widx    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        ref_val <= ui_in;
                        cnt     <= 8'd0;
                        sum     <= '0;
                        widx    <= '0;
                        state   <= S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    cnt <= cnt + 8'd1;
                    if (win_end) begin
                        ref_val <= ui_in;
                        if (final_win) begin
                            sum  <= '0;
                            widx <= '0;
                            cnt  <= 8'd0;
                            if (!cont) begin
                                state <= S_DONE;
                            end
                        end else begin
                            sum  <= sum_next;
                            widx <= widx + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Result register and handshake flags; a result write takes priority over ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= 8'd0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (final_win) begin
            result <= avg;
            valid  <= 1'b1;
            if (ack) begin
                overrun <= 1'b0;
            end else if (valid) begin
                overrun <= 1'b1;
            end
        end else if (ack) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end
    end

    assign uo_out  = result;
    assign uio_out = {state, overrun, (state == S_MEASURE), valid, 3'b000};
    assign uio_oe  = 8'b1111_1000;

endmodule

// File: tb/tb_tt_um_accum_step_decoder.sv
// Testbench for tt_um_accum_step_decoder. Two instances (AVG_LOG2 = 0 and 2)
// share the same inputs; ui_in is driven from a model of the 16-bit step
// accumulator tile. Expected results are the step values themselves (or their
// truncated mean), derived from the stimulus rather than from the DUT.

module tb_tt_um_accum_step_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo0, uio_out0, uio_oe0;
    logic [7:0] uo2, uio_out2, uio_oe2;

    logic [15:0] acc;
    logic [7:0]  step;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [15:0] seed;
        logic [7:0]  step;
        logic [7:0]  exp_uo;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    tt_um_accum_step_decoder #(.AVG_LOG2(0)) dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo0),
        .uio_in (uio_in),
        .uio_out(uio_out0),
        .uio_oe (uio_oe0)
    );

    tt_um_accum_step_decoder #(.AVG_LOG2(2)) dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo2),
        .uio_in (uio_in),
        .uio_out(uio_out2),
        .uio_oe (uio_oe2)
    );

    // Advance one clock, then step the accumulator model away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
        acc   = acc + 16'(step);
        ui_in = acc[15:8];
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic applyStimulus(input logic start, input logic ack, input logic cont);
        uio_in = {5'b00000, cont, ack, start};
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkDut(input string name, input logic [7:0] uo, input logic [7:0] uio,
                            input logic [7:0] exp_uo, input logic exp_v, input logic exp_o,
                            input logic [1:0] exp_st);
        logic exp_busy;
        exp_busy = (exp_st == 2'b01);
        checkOutput({name, " uo_out"}, {24'd0, uo}, {24'd0, exp_uo});
        checkOutput({name, " uio_out"}, {24'd0, uio}, {24'd0, exp_st, exp_o, exp_busy, exp_v, 3'b000});
    endtask

    // Asynchronous reset: outputs must clear without any clock edge
    task automatic doReset(input string name);
        rst_n = 1'b0;
        step  = 8'd0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkDut({name, " dut0"}, uo0, uio_out0, 8'd0, 1'b0, 1'b0, 2'b00);
        checkDut({name, " dut2"}, uo2, uio_out2, 8'd0, 1'b0, 1'b0, 2'b00);
        checkOutput({name, " oe0"}, {24'd0, uio_oe0}, 32'hF8);
        checkOutput({name, " oe2"}, {24'd0, uio_oe2}, 32'hF8);
        ticks(2);
        rst_n = 1'b1;
        tick();
    endtask

    // Load the accumulator seed and pulse start; returns just after edge T
    task automatic startMeasure(input logic [15:0] seed, input logic [7:0] s, input logic cont);
        acc   = seed;
        step  = s;
        ui_in = acc[15:8];
        applyStimulus(1'b0, 1'b0, cont);
        tick();
        applyStimulus(1'b1, 1'b0, cont);
        tick();
        applyStimulus(1'b0, 1'b0, cont);
    endtask

    // Continuous run with random steps per window and random ack placement
    task automatic randomRun();
        logic [7:0] cur, nxt;
        logic [7:0] m0_uo, m2_uo;
        logic       m0_v, m0_o, m2_v, m2_o;
        int         wsum;
        int         mode;
        doReset("rand reset");
        m0_uo = 8'd0; m0_v = 1'b0; m0_o = 1'b0;
        m2_uo = 8'd0; m2_v = 1'b0; m2_o = 1'b0;
        wsum  = 0;
        cur   = 8'($urandom_range(0, 255));
        startMeasure(16'($urandom), cur, 1'b1);
        for (int w = 0; w < 8; w++) begin
            mode = int'($urandom_range(0, 2));
            if (mode == 1) begin
                ticks(100);
                applyStimulus(1'b0, 1'b1, 1'b1);
                tick();
                applyStimulus(1'b0, 1'b0, 1'b1);
                m0_v = 1'b0; m0_o = 1'b0;
                m2_v = 1'b0; m2_o = 1'b0;
                ticks(154);
            end else begin
                ticks(255);
            end
            nxt = 8'($urandom_range(0, 255));
            if (mode == 2) applyStimulus(1'b0, 1'b1, 1'b1);
            step = nxt;
            tick();
            applyStimulus(1'b0, 1'b0, 1'b1);
            wsum += int'(cur);
            m0_uo = cur;
            if (mode == 2) begin
                m0_o = 1'b0;
            end else if (m0_v) begin
                m0_o = 1'b1;
            end
            m0_v = 1'b1;
            if ((w % 4) == 3) begin
                m2_uo = 8'(wsum / 4);
                wsum  = 0;
                if (mode == 2) begin
                    m2_o = 1'b0;
                end else if (m2_v) begin
                    m2_o = 1'b1;
                end
                m2_v = 1'b1;
            end else if (mode == 2) begin
                m2_v = 1'b0;
                m2_o = 1'b0;
            end
            checkDut($sformatf("rand w%0d dut0", w), uo0, uio_out0, m0_uo, m0_v, m0_o, 2'b01);
            checkDut($sformatf("rand w%0d dut2", w), uo2, uio_out2, m2_uo, m2_v, m2_o, 2'b01);
            cur = nxt;
        end
    endtask

    // Safety net so the run can never hang
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b1;
        acc    = 16'd0;
        step   = 8'd0;
        ui_in  = 8'd0;
        uio_in = 8'd0;

        vecs[0] = '{16'h1234, 8'd5,   8'd5};
        vecs[1] = '{16'hFF00, 8'd200, 8'd200};
        vecs[2] = '{16'h1234, 8'd0,   8'd0};
        vecs[3] = '{16'h8000, 8'd255, 8'd255};
        vecs[4] = '{16'h00FF, 8'd1,   8'd1};

        doReset("initial reset");

        // Single-shot table, AVG_LOG2 = 0
        for (int v = 0; v < 5; v++) begin
            doReset($sformatf("vec%0d reset", v));
            startMeasure(vecs[v].seed, vecs[v].step, 1'b0);
            ticks(255);
            checkDut($sformatf("vec%0d T+255", v), uo0, uio_out0, 8'd0, 1'b0, 1'b0, 2'b01);
            tick();
            checkDut($sformatf("vec%0d T+256", v), uo0, uio_out0, vecs[v].exp_uo, 1'b1, 1'b0, 2'b10);
            applyStimulus(1'b0, 1'b1, 1'b0);
            tick();
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkDut($sformatf("vec%0d ack", v), uo0, uio_out0, vecs[v].exp_uo, 1'b0, 1'b0, 2'b00);
        end

        // Averaging over four windows with steps 10, 11, 10, 11
        doReset("avg reset");
        startMeasure(16'h4321, 8'd10, 1'b0);
        ticks(255);
        step = 8'd11;
        ticks(256);
        step = 8'd10;
        ticks(256);
        step = 8'd11;
        ticks(256);
        checkDut("avg T+1023", uo2, uio_out2, 8'd0, 1'b0, 1'b0, 2'b01);
        tick();
        checkDut("avg T+1024", uo2, uio_out2, 8'd10, 1'b1, 1'b0, 2'b10);

        // Continuous mode: overrun, ack on the write edge, ack mid-window
        doReset("cont reset");
        startMeasure(16'h0A0A, 8'd7, 1'b1);
        ticks(255);
        tick();
        checkDut("cont r1", uo0, uio_out0, 8'd7, 1'b1, 1'b0, 2'b01);
        ticks(256);
        checkDut("cont r2 overrun", uo0, uio_out0, 8'd7, 1'b1, 1'b1, 2'b01);
        ticks(255);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkDut("cont r3 ack same edge", uo0, uio_out0, 8'd7, 1'b1, 1'b0, 2'b01);
        ticks(9);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkDut("cont mid ack", uo0, uio_out0, 8'd7, 1'b0, 1'b0, 2'b01);
        ticks(246);
        checkDut("cont r4 single", uo0, uio_out0, 8'd7, 1'b1, 1'b0, 2'b10);

        // Reset in the middle of a measurement discards everything
        doReset("abort reset");
        startMeasure(16'h3000, 8'd3, 1'b0);
        ticks(256);
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        startMeasure(16'h6000, 8'd3, 1'b0);
        ticks(100);
        checkDut("abort T+100", uo0, uio_out0, 8'd3, 1'b0, 1'b0, 2'b01);
        doReset("abort mid");
        startMeasure(16'h5555, 8'd3, 1'b0);
        ticks(256);
        checkDut("after abort", uo0, uio_out0, 8'd3, 1'b1, 1'b0, 2'b10);

        // Start pulses during MEASURE and DONE are ignored; held start runs once
        doReset("start reset");
        startMeasure(16'h7777, 8'd6, 1'b0);
        ticks(50);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        ticks(204);
        checkDut("start ign T+255", uo0, uio_out0, 8'd0, 1'b0, 1'b0, 2'b01);
        tick();
        checkDut("start ign T+256", uo0, uio_out0, 8'd6, 1'b1, 1'b0, 2'b10);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkDut("start in DONE", uo0, uio_out0, 8'd6, 1'b1, 1'b0, 2'b10);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        ticks(300);
        checkDut("start held", uo0, uio_out0, 8'd6, 1'b0, 1'b0, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Randomized continuous runs against the reference model
        for (int r = 0; r < 3; r++) randomRun();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
